bus_rr_arbiter: RTL and testbench



---
 rtl/bus_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant, per-owner burst limit, lock hold.
// Optional STARVE_CHECK_EN builds per-requester wait counters driving sticky starve_err.
//
// state | meaning
// IDLE  | no requester owns the bus, all grant outputs zero
// GRANT | requester gnt_id owns the bus, burst_cnt counts its held cycles
module bus_rr_arbiter #(
  parameter int NREQ       = 2,
  parameter int LOGN       = 1,
  parameter int BURST_LEN  = 4,
  parameter int CNTW       = 3,
  parameter int STARVE_MAX = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] bus_req,
  input  logic            lock,
  output logic [NREQ-1:0] bus_gnt,
  output logic            gnt_valid,
  output logic [LOGN-1:0] gnt_id,
  output logic [CNTW-1:0] burst_cnt,
  output logic [NREQ-1:0] starve_err
);

  if (NREQ < 2 || NREQ > 8 || (1 << LOGN) < NREQ) begin : g_bad_nreq
    $error("bus_rr_arbiter: NREQ must be 2..8 and fit in LOGN bits");
  end
  if (BURST_LEN < 1 || BURST_LEN > (1 << CNTW) - 1) begin : g_bad_burst
    $error("bus_rr_arbiter: BURST_LEN must be 1..2**CNTW-1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("bus_rr_arbiter: STARVE_MAX must be at least 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNTW-1:0] BURST_MAX = CNTW'(BURST_LEN);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [LOGN-1:0] LAST_RST  = LOGN'(NREQ - 1);

  state_t          state;
  logic [LOGN-1:0] last;

  logic            idle_found;
  logic [LOGN-1:0] idle_win;
  logic [NREQ-1:0] idle_oh;
  logic            oth_found;
  logic [LOGN-1:0] oth_win;
  logic [NREQ-1:0] oth_oh;

  // Scan ptr+1 .. ptr+NREQ (mod NREQ); walking far-to-near leaves the nearest hit.
  // The pointer itself is the final candidate and only counts when incl_self is set.
  function automatic logic [LOGN:0] rr_pick(input logic [LOGN-1:0] ptr,
                                            input logic [NREQ-1:0] req,
                                            input logic            incl_self);
    logic            found;
    logic [LOGN-1:0] idx;
    int              cand;
    found = 1'b0;
    idx   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand[LOGN-1:0]] && (off != NREQ || incl_self)) begin
        found = 1'b1;
        idx   = cand[LOGN-1:0];
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {idle_found, idle_win} = rr_pick(last, bus_req, 1'b1);
    {oth_found, oth_win}   = rr_pick(gnt_id, bus_req, 1'b0);
    idle_oh = NREQ'(1) << idle_win;
    oth_oh  = NREQ'(1) << oth_win;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bus_gnt   <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      burst_cnt <= '0;
      last      <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          if (idle_found) begin
            state     <= GRANT;
            bus_gnt   <= idle_oh;
            gnt_valid <= 1'b1;
            gnt_id    <= idle_win;
            burst_cnt <= CNT_ONE;
            last      <= idle_win;
          end else begin
            bus_gnt   <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          // A dropped request outranks lock, so an emptied queue never keeps the bus.
          if (!bus_req[gnt_id]) begin
            if (oth_found) begin
              bus_gnt   <= oth_oh;
              gnt_id    <= oth_win;
              burst_cnt <= CNT_ONE;
              last      <= oth_win;
            end else begin
              state     <= IDLE;
              bus_gnt   <= '0;
              gnt_valid <= 1'b0;
              gnt_id    <= '0;
              burst_cnt <= '0;
            end
          end else if (lock) begin
            if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
          end else if (burst_cnt < BURST_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else if (oth_found) begin
            bus_gnt   <= oth_oh;
            gnt_id    <= oth_win;
            burst_cnt <= CNT_ONE;
            last      <= oth_win;
          end else begin
            burst_cnt <= CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STARVE_CHECK_EN
  localparam int             WAITW    = $clog2(STARVE_MAX + 1);
  localparam logic [WAITW-1:0] WAIT_MAX = WAITW'(STARVE_MAX);

  logic [WAITW-1:0] wait_cnt [NREQ];

  // Lock cycles are deliberately counted so that lock abuse shows up as starvation.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_err <= '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus_req[i] && !bus_gnt[i]) begin
          if (wait_cnt[i] != WAIT_MAX) wait_cnt[i] <= wait_cnt[i] + 1'b1;
          if (wait_cnt[i] >= WAIT_MAX - 1'b1) starve_err[i] <= 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign starve_err = '0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: a 2-requester and a 3-requester instance.
// Expected {gnt, id, valid, burst_cnt, starve_err} is queued as stimulus is driven.
module tb_bus_rr_arbiter;

`ifdef STARVE_CHECK_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic       clock;
  logic       reset2, lock2, reset3, lock3;
  logic [1:0] req2, gnt2, se2;
  logic [2:0] req3, gnt3, se3;
  logic       id2, valid2, valid3;
  logic [1:0] id3;
  logic [2:0] cnt2, cnt3;

  int checks = 0;
  int errors = 0;

  logic [8:0]  sb2 [$];
  logic [11:0] sb3 [$];
  logic [8:0]  obs2;
  logic [11:0] obs3;

  assign obs2 = {gnt2, id2, valid2, cnt2, se2};
  assign obs3 = {gnt3, id3, valid3, cnt3, se3};

  bus_rr_arbiter #(.NREQ(2), .LOGN(1), .BURST_LEN(4), .CNTW(3), .STARVE_MAX(16)) dut2 (
    .clock(clock), .reset(reset2), .bus_req(req2), .lock(lock2),
    .bus_gnt(gnt2), .gnt_valid(valid2), .gnt_id(id2), .burst_cnt(cnt2), .starve_err(se2)
  );

  bus_rr_arbiter #(.NREQ(3), .LOGN(2), .BURST_LEN(4), .CNTW(3), .STARVE_MAX(16)) dut3 (
    .clock(clock), .reset(reset3), .bus_req(req3), .lock(lock3),
    .bus_gnt(gnt3), .gnt_valid(valid3), .gnt_id(id3), .burst_cnt(cnt3), .starve_err(se3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [8:0] pk2(input logic [1:0] g, input logic [2:0] c, input logic [1:0] s);
    return {g, g[1], |g, c, s};
  endfunction

  function automatic logic [11:0] pk3(input logic [2:0] g, input logic [2:0] c);
    logic [1:0] id;
    id = g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
    return {g, id, |g, c, 3'b000};
  endfunction

  function automatic logic [2:0] sat4(input int n);
    return (n >= 4) ? 3'd4 : 3'(n);
  endfunction

  task automatic reset_dut2();
    reset2 = 1'b1; req2 = 2'b00; lock2 = 1'b0;
    @(posedge clock); #1;
    reset2 = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      reset2 = 1'b1; req2 = 2'b11; lock2 = 1'b1;
      sb2.push_back(pk2(2'b00, 3'd0, 2'b00));
      @(posedge clock); #1;
      e = sb2.pop_front(); checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL reset step %0d got %b want %b", i, obs2, e);
      end
    end
    reset2 = 1'b0;
  endtask

  task automatic test_alternate();
    logic [8:0] e;
    reset_dut2();
    for (int i = 0; i < 9; i++) begin
      req2 = 2'b11; lock2 = 1'b0;
      sb2.push_back(pk2((i < 4 || i == 8) ? 2'b01 : 2'b10,
                        (i == 8) ? 3'd1 : 3'((i % 4) + 1), 2'b00));
      @(posedge clock); #1;
      e = sb2.pop_front(); checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL alternate step %0d got %b want %b", i, obs2, e);
      end
    end
  endtask

  task automatic test_single();
    logic [8:0] e;
    reset_dut2();
    for (int i = 0; i < 10; i++) begin
      req2 = 2'b01; lock2 = 1'b0;
      sb2.push_back(pk2(2'b01, 3'((i % 4) + 1), 2'b00));
      @(posedge clock); #1;
      e = sb2.pop_front(); checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL single step %0d got %b want %b", i, obs2, e);
      end
    end
  endtask

  task automatic test_drop();
    logic [8:0] e;
    reset_dut2();
    for (int i = 0; i < 4; i++) begin
      req2 = (i < 2) ? 2'b11 : 2'b10; lock2 = 1'b0;
      sb2.push_back(pk2((i < 2) ? 2'b01 : 2'b10, 3'((i % 2) + 1), 2'b00));
      @(posedge clock); #1;
      e = sb2.pop_front(); checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL drop step %0d got %b want %b", i, obs2, e);
      end
    end
  endtask

  task automatic test_lock();
    logic [8:0] e;
    reset_dut2();
    for (int i = 0; i < 9; i++) begin
      req2 = 2'b11; lock2 = (i < 8);
      sb2.push_back(pk2((i < 8) ? 2'b01 : 2'b10, (i < 8) ? sat4(i + 1) : 3'd1, 2'b00));
      @(posedge clock); #1;
      e = sb2.pop_front(); checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL lock step %0d got %b want %b", i, obs2, e);
      end
    end
  endtask

  // Lock on the same edge as a drop, idle return, and pointer after an idle gap.
  task automatic test_back_to_back();
    logic [8:0] e;
    logic [1:0] r, g;
    logic       l;
    logic [2:0] c;
    reset_dut2();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin r = 2'b11; l = 1'b1; g = 2'b01; c = 3'd1; end
        1:       begin r = 2'b10; l = 1'b1; g = 2'b10; c = 3'd1; end
        2:       begin r = 2'b10; l = 1'b0; g = 2'b10; c = 3'd2; end
        3:       begin r = 2'b00; l = 1'b0; g = 2'b00; c = 3'd0; end
        4:       begin r = 2'b10; l = 1'b0; g = 2'b10; c = 3'd1; end
        default: begin r = 2'b11; l = 1'b0; g = 2'b10; c = 3'd2; end
      endcase
      req2 = r; lock2 = l;
      sb2.push_back(pk2(g, c, 2'b00));
      @(posedge clock); #1;
      e = sb2.pop_front(); checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL back_to_back step %0d got %b want %b", i, obs2, e);
      end
    end
  endtask

  task automatic test_starve();
    logic [8:0] e;
    logic [1:0] s;
    reset_dut2();
    for (int i = 0; i < 22; i++) begin
      reset2 = (i == 21); req2 = 2'b11; lock2 = (i < 20);
      s = (STARVE_ON && i >= 15 && i < 21) ? 2'b10 : 2'b00;
      if (i < 20)       sb2.push_back(pk2(2'b01, sat4(i + 1), s));
      else if (i == 20) sb2.push_back(pk2(2'b10, 3'd1, s));
      else              sb2.push_back(pk2(2'b00, 3'd0, s));
      @(posedge clock); #1;
      e = sb2.pop_front(); checks++;
      if (obs2 !== e) begin
        errors++; $display("FAIL starve step %0d got %b want %b", i, obs2, e);
      end
    end
    reset2 = 1'b0; lock2 = 1'b0; req2 = 2'b00;
  endtask

  task automatic test_nreq3();
    logic [11:0] e;
    logic [2:0]  r, g, c;
    logic        rs, l;
    reset3 = 1'b1; req3 = 3'b000; lock3 = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      rs = 1'b0; l = 1'b0;
      case (i)
        0:       begin r = 3'b001; g = 3'b001; c = 3'd1; end
        1:       begin r = 3'b000; g = 3'b000; c = 3'd0; end
        2, 3, 4, 5: begin r = 3'b101; g = 3'b100; c = 3'(i - 1); end
        6, 7:    begin r = 3'b101; g = 3'b001; c = 3'(i - 5); end
        8:       begin r = 3'b101; rs = 1'b1; l = 1'b1; g = 3'b000; c = 3'd0; end
        default: begin r = 3'b101; g = 3'b001; c = 3'd1; end
      endcase
      reset3 = rs; req3 = r; lock3 = l;
      sb3.push_back(pk3(g, c));
      @(posedge clock); #1;
      e = sb3.pop_front(); checks++;
      if (obs3 !== e) begin
        errors++; $display("FAIL nreq3 step %0d got %b want %b", i, obs3, e);
      end
    end
    reset3 = 1'b0;
  endtask

  initial begin
    reset2 = 1'b1; req2 = 2'b00; lock2 = 1'b0;
    reset3 = 1'b1; req3 = 3'b000; lock3 = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_alternate();
    test_single();
    test_drop();
    test_lock();
    test_back_to_back();
    test_starve();
    test_nreq3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
